// File: rtl/tx_sync_multi_tmr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tx_sync_multi_tmr_vote
// Description : Bitwise 2-of-3 majority voter.
// Ports       : a, b, c - the three copies; y - voted value.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tx_sync_multi_tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);
  assign y = (a & b) | (a & c) | (b & c);
endmodule

//------------------------------------------------------------------------------
// Module      : tx_sync_multi_tmr
// Description : Triplicated multi-lane GTX TX phase-alignment sequencer.
//               One voted FSM steps all lanes through delay-aligner reset,
//               an enable-only wait, PMA set-phase and finally Ready.
// Ports       : clk               - TX user clock (TXUSRCLK2)
//               rst_n             - asynchronous active-low reset
//               resync            - restart request, level sampled
//               lane_en           - per-lane output mask
//               txdlyalignreset   - per-lane delay-aligner reset
//               txenpmaphasealign - per-lane PMA phase-align enable
//               txpmasetphase     - per-lane PMA set-phase
//               sync_done         - alignment complete
//               sync_count        - Ready entries since reset (saturating)
//               seu_err           - one-cycle pulse on copy/vote disagreement
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tx_sync_multi_tmr #(
  parameter int NLANES    = 4,
  parameter int ALIGN_CNT = 20,
  parameter int WAIT_CNT  = 32,
  parameter int SYNC_CNT  = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resync,
  input  logic [NLANES-1:0] lane_en,
  output logic [NLANES-1:0] txdlyalignreset,
  output logic [NLANES-1:0] txenpmaphasealign,
  output logic [NLANES-1:0] txpmasetphase,
  output logic              sync_done,
  output logic [7:0]        sync_count,
  output logic              seu_err
);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_ALIGN = 3'b001;
  localparam logic [2:0] ST_PHASE = 3'b010;
  localparam logic [2:0] ST_READY = 3'b011;
  localparam logic [2:0] ST_WAIT  = 3'b100;

  localparam logic [7:0]  C_ALIGN = 8'(ALIGN_CNT);
  localparam logic [7:0]  C_WAIT  = 8'(WAIT_CNT);
  localparam logic [15:0] C_SYNC  = 16'(SYNC_CNT);

  // Voted views of the triplicated registers
  logic [2:0]        v_state;
  logic [7:0]        v_acnt;
  logic [7:0]        v_wcnt;
  logic [15:0]       v_scnt;
  logic [7:0]        v_cnt;
  logic [NLANES-1:0] v_align;
  logic [NLANES-1:0] v_en;
  logic [NLANES-1:0] v_set;
  logic              v_done;
  logic              v_seu;

  logic restart;
  logic any_mis;

  // RESYNC overrides every transition; in Idle the FSM goes to Align_Reset anyway.
  assign restart = resync && (v_state != ST_IDLE);

  //----------------------------------------------------------------------------
  // Three identical copies. Each copy derives its next value solely from the
  // voted values, so a corrupted copy is overwritten on the following edge.
  //----------------------------------------------------------------------------
  for (genvar i = 0; i < 3; i++) begin : g_copy
    logic [2:0]        state_r, state_n;
    logic [7:0]        acnt_r, acnt_n;
    logic [7:0]        wcnt_r, wcnt_n;
    logic [15:0]       scnt_r, scnt_n;
    logic [7:0]        cnt_r, cnt_n;
    logic [NLANES-1:0] align_r, align_n;
    logic [NLANES-1:0] en_r, en_n;
    logic [NLANES-1:0] set_r, set_n;
    logic              done_r, done_n;
    logic              seu_r, seu_n;

    // State/counter/output register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= ST_IDLE;
        acnt_r  <= '0;
        wcnt_r  <= '0;
        scnt_r  <= '0;
        cnt_r   <= '0;
        align_r <= '0;
        en_r    <= '0;
        set_r   <= '0;
        done_r  <= 1'b0;
        seu_r   <= 1'b0;
      end else begin
        state_r <= state_n;
        acnt_r  <= acnt_n;
        wcnt_r  <= wcnt_n;
        scnt_r  <= scnt_n;
        cnt_r   <= cnt_n;
        align_r <= align_n;
        en_r    <= en_n;
        set_r   <= set_n;
        done_r  <= done_n;
        seu_r   <= seu_n;
      end
    end

    // Next-state and counter logic
    always_comb begin
      state_n = ST_IDLE;
      if (restart) begin
        state_n = ST_ALIGN;
      end else begin
        case (v_state)
          ST_IDLE:  state_n = ST_ALIGN;
          ST_ALIGN: state_n = (v_acnt == C_ALIGN) ? ST_WAIT  : ST_ALIGN;
          ST_WAIT:  state_n = (v_wcnt == C_WAIT)  ? ST_PHASE : ST_WAIT;
          ST_PHASE: state_n = (v_scnt == C_SYNC)  ? ST_READY : ST_PHASE;
          ST_READY: state_n = ST_READY;
          default:  state_n = ST_IDLE;
        endcase
      end

      // Counters load 1 on entry, count while held, and are 0 elsewhere.
      // A restart from Align_Reset counts as a fresh entry.
      acnt_n = '0;
      wcnt_n = '0;
      scnt_n = '0;
      if (state_n == ST_ALIGN)
        acnt_n = (v_state == ST_ALIGN && !restart) ? v_acnt + 8'd1 : 8'd1;
      if (state_n == ST_WAIT)
        wcnt_n = (v_state == ST_WAIT) ? v_wcnt + 8'd1 : 8'd1;
      if (state_n == ST_PHASE)
        scnt_n = (v_state == ST_PHASE) ? v_scnt + 16'd1 : 16'd1;

      cnt_n = v_cnt;
      if (state_n == ST_READY && v_state != ST_READY && v_cnt != 8'hFF)
        cnt_n = v_cnt + 8'd1;

      seu_n = any_mis;
    end

    // Outputs decoded from the next state so they move with the state.
    always_comb begin
      align_n = '0;
      en_n    = '0;
      set_n   = '0;
      done_n  = 1'b0;
      case (state_n)
        ST_ALIGN: align_n = lane_en;
        ST_WAIT:  en_n    = lane_en;
        ST_PHASE: begin
          en_n  = lane_en;
          set_n = lane_en;
        end
        ST_READY: begin
          en_n   = lane_en;
          done_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  //----------------------------------------------------------------------------
  // Voters
  //----------------------------------------------------------------------------
  tx_sync_multi_tmr_vote #(.W(3)) u_v_state (
    .a(g_copy[0].state_r), .b(g_copy[1].state_r), .c(g_copy[2].state_r), .y(v_state));
  tx_sync_multi_tmr_vote #(.W(8)) u_v_acnt (
    .a(g_copy[0].acnt_r), .b(g_copy[1].acnt_r), .c(g_copy[2].acnt_r), .y(v_acnt));
  tx_sync_multi_tmr_vote #(.W(8)) u_v_wcnt (
    .a(g_copy[0].wcnt_r), .b(g_copy[1].wcnt_r), .c(g_copy[2].wcnt_r), .y(v_wcnt));
  tx_sync_multi_tmr_vote #(.W(16)) u_v_scnt (
    .a(g_copy[0].scnt_r), .b(g_copy[1].scnt_r), .c(g_copy[2].scnt_r), .y(v_scnt));
  tx_sync_multi_tmr_vote #(.W(8)) u_v_cnt (
    .a(g_copy[0].cnt_r), .b(g_copy[1].cnt_r), .c(g_copy[2].cnt_r), .y(v_cnt));
  tx_sync_multi_tmr_vote #(.W(NLANES)) u_v_align (
    .a(g_copy[0].align_r), .b(g_copy[1].align_r), .c(g_copy[2].align_r), .y(v_align));
  tx_sync_multi_tmr_vote #(.W(NLANES)) u_v_en (
    .a(g_copy[0].en_r), .b(g_copy[1].en_r), .c(g_copy[2].en_r), .y(v_en));
  tx_sync_multi_tmr_vote #(.W(NLANES)) u_v_set (
    .a(g_copy[0].set_r), .b(g_copy[1].set_r), .c(g_copy[2].set_r), .y(v_set));
  tx_sync_multi_tmr_vote #(.W(1)) u_v_done (
    .a(g_copy[0].done_r), .b(g_copy[1].done_r), .c(g_copy[2].done_r), .y(v_done));
  tx_sync_multi_tmr_vote #(.W(1)) u_v_seu (
    .a(g_copy[0].seu_r), .b(g_copy[1].seu_r), .c(g_copy[2].seu_r), .y(v_seu));

  // Any copy of the state or a counter disagreeing with its vote.
  logic mis_state, mis_acnt, mis_wcnt, mis_scnt, mis_cnt;

  assign mis_state = (g_copy[0].state_r != v_state) | (g_copy[1].state_r != v_state) |
                     (g_copy[2].state_r != v_state);
  assign mis_acnt  = (g_copy[0].acnt_r != v_acnt) | (g_copy[1].acnt_r != v_acnt) |
                     (g_copy[2].acnt_r != v_acnt);
  assign mis_wcnt  = (g_copy[0].wcnt_r != v_wcnt) | (g_copy[1].wcnt_r != v_wcnt) |
                     (g_copy[2].wcnt_r != v_wcnt);
  assign mis_scnt  = (g_copy[0].scnt_r != v_scnt) | (g_copy[1].scnt_r != v_scnt) |
                     (g_copy[2].scnt_r != v_scnt);
  assign mis_cnt   = (g_copy[0].cnt_r != v_cnt) | (g_copy[1].cnt_r != v_cnt) |
                     (g_copy[2].cnt_r != v_cnt);
  assign any_mis   = mis_state | mis_acnt | mis_wcnt | mis_scnt | mis_cnt;

  assign txdlyalignreset   = v_align;
  assign txenpmaphasealign = v_en;
  assign txpmasetphase     = v_set;
  assign sync_done         = v_done;
  assign sync_count        = v_cnt;
  assign seu_err           = v_seu;

endmodule
`default_nettype wire

// File: tb/tb_tx_sync_multi_tmr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_tx_sync_multi_tmr
// Description : Directed bench for tx_sync_multi_tmr with short step counts
//               (A=4, W=3, S=5, four lanes).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_tx_sync_multi_tmr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       resync = 1'b0;
  logic [3:0] lane_en = 4'hF;
  logic [3:0] txdlyalignreset;
  logic [3:0] txenpmaphasealign;
  logic [3:0] txpmasetphase;
  logic       sync_done;
  logic [7:0] sync_count;
  logic       seu_err;

  int vectors = 0;
  int miscompares = 0;

  tx_sync_multi_tmr #(
    .NLANES(4), .ALIGN_CNT(4), .WAIT_CNT(3), .SYNC_CNT(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .resync(resync),
    .lane_en(lane_en),
    .txdlyalignreset(txdlyalignreset),
    .txenpmaphasealign(txenpmaphasealign),
    .txpmasetphase(txpmasetphase),
    .sync_done(sync_done),
    .sync_count(sync_count),
    .seu_err(seu_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_align"}, 32'(txdlyalignreset), 32'h0);
    chk({tag, "_en"},    32'(txenpmaphasealign), 32'h0);
    chk({tag, "_set"},   32'(txpmasetphase), 32'h0);
    chk({tag, "_done"},  32'(sync_done), 32'h0);
    chk({tag, "_count"}, 32'(sync_count), 32'h0);
    chk({tag, "_seu"},   32'(seu_err), 32'h0);
  endtask

  // Expected outputs at cycle c (1 = first edge after start) for A=4, W=3, S=5:
  // align 1..4, enable from 5, set-phase 8..12, done and count+1 from 13.
  task automatic expect_cycle(input int c, input logic [3:0] m, input int base,
                              input logic seu_exp);
    logic [3:0] e_align, e_en, e_set;
    e_align = (c >= 1 && c <= 4)  ? m : 4'h0;
    e_en    = (c >= 5)            ? m : 4'h0;
    e_set   = (c >= 8 && c <= 12) ? m : 4'h0;
    chk($sformatf("c%0d_align", c), 32'(txdlyalignreset), 32'(e_align));
    chk($sformatf("c%0d_en", c),    32'(txenpmaphasealign), 32'(e_en));
    chk($sformatf("c%0d_set", c),   32'(txpmasetphase), 32'(e_set));
    chk($sformatf("c%0d_done", c),  32'(sync_done), (c >= 13) ? 32'h1 : 32'h0);
    chk($sformatf("c%0d_count", c), 32'(sync_count), 32'((c >= 13) ? base + 1 : base));
    chk($sformatf("c%0d_seu", c),   32'(seu_err), 32'(seu_exp));
  endtask

  task automatic run_cycles(input int first, input int last, input logic [3:0] m,
                            input int base);
    for (int c = first; c <= last; c++) begin
      tick();
      expect_cycle(c, m, base, 1'b0);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero(tag);
    rst_n = 1'b1;          // next rising edge is cycle 1
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset state and nominal sequence, all lanes
    lane_en = 4'hF;
    do_reset("rst0");
    run_cycles(1, 14, 4'hF, 0);

    // 2. One-cycle RESYNC from Ready: the sampling edge is the new cycle 1
    resync = 1'b1;
    tick();
    resync = 1'b0;
    expect_cycle(1, 4'hF, 1, 1'b0);
    run_cycles(2, 13, 4'hF, 1);

    // 3. RESYNC on the edge where scnt == S wins over Ready
    resync = 1'b1;
    tick();
    resync = 1'b0;
    expect_cycle(1, 4'hF, 2, 1'b0);
    run_cycles(2, 12, 4'hF, 2);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    expect_cycle(1, 4'hF, 2, 1'b0);   // back in Align_Reset, count unchanged
    run_cycles(2, 13, 4'hF, 2);

    // 4. Lane mask 0101
    lane_en = 4'b0101;
    do_reset("rst1");
    run_cycles(1, 13, 4'b0101, 0);

    // 5. SEU injection during the wait step
    lane_en = 4'hF;
    do_reset("rst2");
    run_cycles(1, 5, 4'hF, 0);
    force dut.g_copy[1].state_r = 3'b101;
    force dut.g_copy[2].acnt_r  = 8'hA5;
    #1;
    release dut.g_copy[1].state_r;
    release dut.g_copy[2].acnt_r;
    tick();
    expect_cycle(6, 4'hF, 0, 1'b1);
    run_cycles(7, 14, 4'hF, 0);

    // 6. Asynchronous reset mid-sequence, then a clean restart
    do_reset("rst3");
    run_cycles(1, 9, 4'hF, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async");
    tick();
    rst_n = 1'b1;
    run_cycles(1, 13, 4'hF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
